hazard_ctrl: RTL and testbench

- Pipeline hazard controller fed directly by the ID-stage register-read decoder (rs1, rs2, re1, re2).
- Keeps a shadow scoreboard of destination registers for the instructions in EX, MEM and WB.
- Generates load-use stalls, bubble insertion, control-hazard flushes and registered forwarding selects for the EX-stage operand muxes.
- Also counts stall and flush events for performance visibility.

---
 rtl/hazard_ctrl_pkg.sv | 56 +++++
 rtl/hazard_sat_counter.sv | 35 +++
 rtl/hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared pipeline definitions. This package holds the forwarding
//               select encoding, the RV32 opcode[6:2] constants used by the ID
//               read decoder, the shadow scoreboard slot layout, the hazard
//               action encoding and the source-operand match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // EX operand mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM pipeline register result
    localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB pipeline register result

    // opcode[6:2] values recognised by the ID register-read decoder
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP_IMM = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    // Shadow scoreboard entry for one downstream pipeline stage
    typedef struct packed {
        logic       v;   // stage holds a real instruction
        logic [4:0] rd;  // destination register
        logic       we;  // instruction writes rd
        logic       ld;  // instruction is a load
    } slot_t;

    // What the pipeline does on the coming edge, in priority order
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'b00,
        ACT_FREEZE  = 2'b01,
        ACT_FLUSH   = 2'b10,
        ACT_STALL   = 2'b11
    } hz_action_t;

    // A slot produces the value an ID operand wants. Writes to x0 are
    // architecturally discarded, so they never match.
    function automatic logic slot_match(
        input slot_t      s,
        input logic [4:0] rs,
        input logic       re,
        input logic       id_valid
    );
        return s.v & s.we & (s.rd != 5'd0) & (s.rd == rs) & re & id_valid;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sat_counter
// Description : Saturating event counter. It increments on inc unless hold is
//               set, and it stops at all-ones.
// Ports       : clk, rst (async, active-high), inc, hold, count[WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             hold,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !hold && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. It keeps a shadow scoreboard of the
//               destinations in EX/MEM/WB, raises load-use stalls, bubbles,
//               redirect flushes and memory freezes in the same cycle as the
//               cause, and registers the EX operand forwarding selects. It
//               also counts stall and flush events.
// Ports       : clk, rst (async, active-high)
//               id_valid, re1, re2, rs1, rs2, id_rd, id_we, id_is_load : ID info
//               ex_redirect, mem_busy                                  : causes
//               stall_if, stall_id, flush_id, bubble_ex, freeze        : ctrl
//               fwd_a, fwd_b                                           : fwd sel
//               stall_cnt, flush_cnt                                   : perf
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W            = 32,
    parameter bit RF_WRITE_THROUGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             re1,
    input  logic             re2,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    slot_t      r_ex;
    slot_t      r_mem;
    slot_t      r_wb;
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    logic       w_ex_m1;
    logic       w_ex_m2;
    logic       w_mem_m1;
    logic       w_mem_m2;
    logic       w_lu;
    hz_action_t w_act;
    logic [1:0] w_fwd_a_nxt;
    logic [1:0] w_fwd_b_nxt;
    slot_t      w_id_slot;

    // ------------------------------------------------------------------
    // Operand matching against the scoreboard
    // ------------------------------------------------------------------
    assign w_ex_m1  = slot_match(r_ex,  rs1, re1, id_valid);
    assign w_ex_m2  = slot_match(r_ex,  rs2, re2, id_valid);
    assign w_mem_m1 = slot_match(r_mem, rs1, re1, id_valid);
    assign w_mem_m2 = slot_match(r_mem, rs2, re2, id_valid);

    // A load in EX has no data until MEM completes, so the consumer must wait.
    assign w_lu = r_ex.ld & (w_ex_m1 | w_ex_m2);

    // The nearer producer holds the younger value, so it takes precedence.
    assign w_fwd_a_nxt = w_ex_m1 ? FWD_MEM : (w_mem_m1 ? FWD_WB : FWD_RF);
    assign w_fwd_b_nxt = w_ex_m2 ? FWD_MEM : (w_mem_m2 ? FWD_WB : FWD_RF);

    assign w_id_slot = '{v: id_valid, rd: id_rd, we: id_we, ld: id_is_load};

    // ------------------------------------------------------------------
    // Action selection. While memory is busy, EX is held and re-presents
    // any redirect or load-use on release, so those causes are ignored.
    // ------------------------------------------------------------------
    always_comb begin
        w_act = ACT_ADVANCE;
        if (mem_busy) begin
            w_act = ACT_FREEZE;
        end else if (ex_redirect) begin
            w_act = ACT_FLUSH;
        end else if (w_lu) begin
            w_act = ACT_STALL;
        end
    end

    // Control outputs. Reset forces them low at once, even with causes asserted.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        freeze    = 1'b0;
        if (!rst) begin
            case (w_act)
                ACT_FREEZE: begin
                    freeze   = 1'b1;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end
                ACT_FLUSH: begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                ACT_STALL: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard shift and registered forwarding selects
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            case (w_act)
                ACT_FREEZE: ;
                ACT_FLUSH, ACT_STALL: begin
                    r_ex    <= '0;
                    r_mem   <= r_ex;
                    r_wb    <= r_mem;
                    r_fwd_a <= FWD_RF;
                    r_fwd_b <= FWD_RF;
                end
                default: begin
                    r_ex    <= w_id_slot;
                    r_mem   <= r_ex;
                    r_wb    <= r_mem;
                    r_fwd_a <= w_fwd_a_nxt;
                    r_fwd_b <= w_fwd_b_nxt;
                end
            endcase
        end
    end

    assign fwd_a = r_fwd_a;
    assign fwd_b = r_fwd_b;

    // The register file forwards same-cycle WB writes internally, so the WB
    // slot never feeds a select. It is kept so the scoreboard mirrors the
    // pipeline. Only the write-through configuration is supported.
    generate
        if (RF_WRITE_THROUGH) begin : g_wb_write_through
            logic w_unused_wb;
            assign w_unused_wb = ^r_wb;
        end else begin : g_wb_no_write_through
            logic w_unused_wb;
            assign w_unused_wb = ^r_wb;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    hazard_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_act == ACT_STALL),
        .hold  (mem_busy),
        .count (stall_cnt)
    );

    hazard_sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_act == ACT_FLUSH),
        .hold  (mem_busy),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl. It uses 4-bit
//               counters so that saturation can be reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_valid = 1'b0;
    logic             re1 = 1'b0;
    logic             re2 = 1'b0;
    logic [4:0]       rs1 = '0;
    logic [4:0]       rs2 = '0;
    logic [4:0]       id_rd = '0;
    logic             id_we = 1'b0;
    logic             id_is_load = 1'b0;
    logic             ex_redirect = 1'b0;
    logic             mem_busy = 1'b0;
    logic             stall_if;
    logic             stall_id;
    logic             flush_id;
    logic             bubble_ex;
    logic             freeze;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // {stall_if, stall_id, flush_id, bubble_ex, freeze}
    logic [4:0] w_ctl;
    assign w_ctl = {stall_if, stall_id, flush_id, bubble_ex, freeze};

    localparam logic [4:0] CTL_NONE   = 5'b00000;
    localparam logic [4:0] CTL_LU     = 5'b11010;
    localparam logic [4:0] CTL_FLUSH  = 5'b00110;
    localparam logic [4:0] CTL_FREEZE = 5'b11001;

    hazard_ctrl #(
        .CNT_W            (CNT_W),
        .RF_WRITE_THROUGH (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .re1         (re1),
        .re2         (re2),
        .rs1         (rs1),
        .rs2         (rs2),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .mem_busy    (mem_busy),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .flush_id    (flush_id),
        .bubble_ex   (bubble_ex),
        .freeze      (freeze),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an instruction in ID
    task automatic set_id(input logic v, input logic r1e, input logic [4:0] r1,
                          input logic r2e, input logic [4:0] r2,
                          input logic [4:0] rd, input logic we, input logic ld);
        id_valid   = v;
        re1        = r1e;
        rs1        = r1;
        re2        = r2e;
        rs2        = r2;
        id_rd      = rd;
        id_we      = we;
        id_is_load = ld;
        #1;
    endtask

    task automatic set_nop();
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance to one time unit past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        check("reset_ctl", 32'(w_ctl), 32'(CTL_NONE));
        check("reset_fwd", 32'({fwd_a, fwd_b}), 32'h0);
        check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
        check("reset_flush_cnt", 32'(flush_cnt), 32'h0);
        rst = 1'b0;

        // ---------------- load-use: lw x5 ; add x6,x5,x7 ----------------
        set_id(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1);
        tick();
        set_id(1, 1, 5'd5, 1, 5'd7, 5'd6, 1, 0);
        check("lu_ctl", 32'(w_ctl), 32'(CTL_LU));
        check("lu_cnt_before", 32'(stall_cnt), 32'h0);
        tick();
        check("lu_cnt_after", 32'(stall_cnt), 32'h1);
        check("lu_ctl_released", 32'(w_ctl), 32'(CTL_NONE));
        check("lu_fwd_bubble", 32'({fwd_a, fwd_b}), 32'h0);
        tick();
        set_nop();
        check("lu_fwd_a", 32'(fwd_a), 32'h2);
        check("lu_fwd_b", 32'(fwd_b), 32'h0);

        // ---------------- ALU chain: addi x3 ; sub x4,x1,x3 ----------------
        set_id(1, 1, 5'd1, 0, 5'd0, 5'd3, 1, 0);
        tick();
        set_id(1, 1, 5'd1, 1, 5'd3, 5'd4, 1, 0);
        check("alu_ctl", 32'(w_ctl), 32'(CTL_NONE));
        tick();
        check("alu_fwd_a", 32'(fwd_a), 32'h0);
        check("alu_fwd_b", 32'(fwd_b), 32'h1);

        // ---------------- nearest wins: EX=add x3, MEM=add x3 ----------------
        set_id(1, 0, 5'd0, 0, 5'd0, 5'd3, 1, 0);
        tick();
        tick();
        set_id(1, 1, 5'd3, 0, 5'd0, 5'd8, 1, 0);
        check("near_ctl", 32'(w_ctl), 32'(CTL_NONE));
        tick();
        check("near_fwd_a", 32'(fwd_a), 32'h1);

        // ---------------- x0 never matches ----------------
        set_id(1, 0, 5'd0, 0, 5'd0, 5'd0, 1, 1);
        tick();
        set_id(1, 1, 5'd0, 0, 5'd0, 5'd10, 1, 0);
        check("x0_ctl", 32'(w_ctl), 32'(CTL_NONE));
        tick();
        check("x0_fwd_a", 32'(fwd_a), 32'h0);

        // ---------------- read-enable gating ----------------
        set_id(1, 0, 5'd0, 0, 5'd0, 5'd9, 1, 1);
        tick();
        set_id(1, 0, 5'd9, 0, 5'd9, 5'd11, 1, 0);
        check("re_ctl", 32'(w_ctl), 32'(CTL_NONE));
        tick();
        check("re_fwd", 32'({fwd_a, fwd_b}), 32'h0);

        // ---------------- redirect while load-use ----------------
        set_id(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1);
        tick();
        set_id(1, 1, 5'd5, 0, 5'd0, 5'd6, 1, 0);
        ex_redirect = 1'b1;
        #1;
        check("redir_ctl", 32'(w_ctl), 32'(CTL_FLUSH));
        tick();
        ex_redirect = 1'b0;
        set_nop();
        check("redir_flush_cnt", 32'(flush_cnt), 32'h1);
        check("redir_stall_cnt", 32'(stall_cnt), 32'h1);

        // ---------------- mem_busy during a load-use ----------------
        set_id(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1);
        tick();
        set_id(1, 1, 5'd5, 0, 5'd0, 5'd6, 1, 0);
        mem_busy = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("busy_ctl", 32'(w_ctl), 32'(CTL_FREEZE));
            tick();
            check("busy_stall_cnt", 32'(stall_cnt), 32'h1);
            check("busy_flush_cnt", 32'(flush_cnt), 32'h1);
        end
        mem_busy = 1'b0;
        #1;
        check("busy_release_ctl", 32'(w_ctl), 32'(CTL_LU));
        tick();
        check("busy_one_bubble_ctl", 32'(w_ctl), 32'(CTL_NONE));
        check("busy_stall_cnt_after", 32'(stall_cnt), 32'h2);
        tick();
        set_nop();
        check("busy_fwd_a", 32'(fwd_a), 32'h2);

        // ---------------- async reset mid-stall ----------------
        set_id(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1);
        tick();
        set_id(1, 1, 5'd5, 0, 5'd0, 5'd6, 1, 0);
        check("arst_pre_ctl", 32'(w_ctl), 32'(CTL_LU));
        #1;
        rst = 1'b1;
        #1;
        check("arst_ctl", 32'(w_ctl), 32'(CTL_NONE));
        check("arst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("arst_flush_cnt", 32'(flush_cnt), 32'h0);
        check("arst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
        #1;
        rst = 1'b0;
        set_nop();

        // ---------------- stall counter saturation ----------------
        for (int i = 0; i < 15; i++) begin
            set_id(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1);
            tick();
            set_id(1, 0, 5'd0, 1, 5'd5, 5'd6, 1, 0);
            tick();
        end
        check("sat_full", 32'(stall_cnt), 32'hF);
        set_id(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1);
        tick();
        set_id(1, 0, 5'd0, 1, 5'd5, 5'd6, 1, 0);
        check("sat_lu_ctl", 32'(w_ctl), 32'(CTL_LU));
        tick();
        check("sat_hold", 32'(stall_cnt), 32'hF);
        set_nop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
